// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the five-stage MIPS pipeline.
// Holds the fetch PC that addresses the combinational instruction memory and
// registers the returned instruction, its PC and PC+8 into the IF/ID register.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   stall          freeze PC, IF/ID and the fetch counter
//   clr_d          load a bubble into IF/ID on the next advancing edge
//   redirect_valid control transfer taken by the instruction in D
//   redirect_pc    target from D (bits [1:0] ignored)
//   instr_f        instruction returned by IM for pc_f
//   pc_f           registered fetch address
//   instr_d        IF/ID instruction
//   pc_d           IF/ID PC of instr_d
//   pc8_d          IF/ID link value pc_d+8
//   valid_d        IF/ID holds a real instruction (0 = bubble)
//   fetch_count    advancing edges since reset
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        clr_d,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic        valid_d,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_seq;
    logic [31:0] pc_next;

    // Sequential and redirect targets are both word-aligned so pc_f[1:0]
    // can never leave 2'b00.
    always_comb begin
        pc_seq  = pc_f + PC_STEP;
        pc_next = {pc_seq[31:2], 2'b00};
        if (redirect_valid) begin
            pc_next = {redirect_pc[31:2], 2'b00};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f <= RESET_PC;
        end else if (!stall) begin
            pc_f <= pc_next;
        end
    end

    // A redirect does not flush IF/ID: the instruction fetched alongside the
    // branch in D is its delay slot and must still advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_d <= '0;
            pc_d    <= '0;
            pc8_d   <= '0;
            valid_d <= 1'b0;
        end else if (!stall) begin
            if (clr_d) begin
                instr_d <= '0;
                pc_d    <= '0;
                pc8_d   <= '0;
                valid_d <= 1'b0;
            end else begin
                instr_d <= instr_f;
                pc_d    <= pc_f;
                pc8_d   <= pc_f + 32'd8;
                valid_d <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count <= '0;
        end else if (!stall) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the P5 five-stage MIPS pipeline.
- Holds the PC register that addresses the combinational instruction memory (IM), and takes the returned instruction.
- Registers the instruction, its PC and PC+8 into the IF/ID pipeline register for the decode stage.
- Handles stall freeze, delay-slot redirect (branch/j/jal/jr target from D) and IF/ID clear.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset; first fetch address.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  from hazard unit; freeze PC and IF/ID.
- clr_d  input  1  load bubble into IF/ID on the next advancing edge.
- redirect_valid  input  1  D-stage control-transfer taken this cycle.
- redirect_pc  input  32  target address from D; bits [1:0] ignored.
- instr_f  input  32  instruction returned combinationally by IM for pc_f.
- pc_f  output  32  current fetch address to IM; registered.
- instr_d  output  32  IF/ID instruction.
- pc_d  output  32  IF/ID PC of instr_d.
- pc8_d  output  32  IF/ID pc_d+8 (jal/jalr link value).
- valid_d  output  1  IF/ID holds a real instruction (0 = bubble).
- fetch_count  output  32  number of advancing edges since reset (perf counter).

Behaviour:
Reset:
- reset=1 forces, without waiting for a clock: pc_f=RESET_PC, instr_d=0, pc_d=0, pc8_d=0, valid_d=0, fetch_count=0.
- Deasserting reset between edges: the first advancing edge after release fetches RESET_PC.
- Reset asserted mid-stall or mid-redirect discards the pending redirect; no state survives.

Every rising clk edge with reset=0, in priority order:
- stall=1:
  - pc_f, instr_d, pc_d, pc8_d, valid_d and fetch_count all hold.
  - redirect_valid and clr_d are ignored. The D instruction is re-presented next cycle and re-asserts its redirect.
- stall=0, clr_d=1:
  - IF/ID loads instr_d=0, pc_d=0, pc8_d=0, valid_d=0.
  - PC update below still applies.
  - fetch_count increments.
- stall=0, clr_d=0:
  - IF/ID loads instr_d=instr_f, pc_d=pc_f, pc8_d=pc_f+8, valid_d=1.
  - fetch_count increments.
- PC update when stall=0:
  - redirect_valid=1: pc_f <= {redirect_pc[31:2],2'b00}.
  - Otherwise: pc_f <= pc_f+PC_STEP.

Delay slot:
- The redirect is raised while the branch is in D, so the instruction in IF that cycle (the delay slot) still enters IF/ID normally.
- The target is fetched one cycle later. No automatic flush on redirect.

Arithmetic:
- All PC sums are modulo 2^32. pc_f=32'hFFFF_FFFC advances to 32'h0000_0000; pc8_d wraps likewise.
- fetch_count wraps from 32'hFFFF_FFFF to 0.

Timing:
- pc_f is a pure register output; there is no combinational path from any input to pc_f.
- instr_f is sampled only at the clock edge.
- All outputs change only on clk edges, or immediately on reset assertion.
- pc_f[1:0] is always 2'b00.

Test Plan:
- Reset then 4 free-running cycles, IM word at k = 32'h1000_0000+k: pc_f 3000→3004→3008→300C→3010; after edge 2: instr_d=1000_0001, pc_d=3004, pc8_d=300C, valid_d=1; fetch_count=4.
- stall=1 for 3 cycles at pc_f=3008: pc_f, instr_d, pc_d, fetch_count unchanged; with redirect_valid=1, redirect_pc=3100 during the stall, redirect is ignored and pc_f stays 3008.
- Branch at 3004 in D raises redirect_valid=1, redirect_pc=32'h0000_3103: next edge pc_f=3100, IF/ID gets delay slot at 3008 (valid_d=1); following edge IF/ID pc_d=3100.
- clr_d=1, stall=0 at pc_f=300C: IF/ID becomes instr_d=0, valid_d=0, pc_d=0; pc_f=3010; fetch_count increments.
- Redirect to FFFF_FFFC then free-run: pc_f FFFF_FFFC→0000_0000; pc8_d for that fetch = 0000_0004.
- Assert reset asynchronously between edges while pc_f=3010 and stall=1: outputs go to reset values before the next edge; after release, first fetch at 3000.
